// File: rtl/seq_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_gen_pkg
//  Purpose  : Shared types and widths for the serial sequence generator.
//             Holds the FSM state encoding and the field widths of the
//             pattern, repetition-count and gap-count inputs.
//  Revision : 1.0  initial release
// ============================================================================
package seq_gen_pkg;

  localparam int PAT_W = 4;  // pattern word width, sent MSB first
  localparam int REP_W = 4;  // repetition count width (1..15)
  localparam int GAP_W = 2;  // idle cycles between repetitions (0..3)
  localparam int IDX_W = $clog2(PAT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage : seq_gen_pkg
`default_nettype wire

// File: rtl/seq_gen_shreg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_gen_shreg
//  Purpose  : PAT_W-bit load/shift register presenting its MSB. Load takes
//             priority over shift; clr empties the register.
//  Ports    : clk     - clock
//             clr     - synchronous active-high clear
//             i_load  - parallel load of i_d
//             i_shift - shift left by one, i_si entering at the LSB
//             i_si    - serial input
//             i_d     - parallel load data
//             o_msb   - registered MSB of the register
//  Revision : 1.0  initial release
// ============================================================================
module seq_gen_shreg
  import seq_gen_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_si,
  input  logic [PAT_W-1:0] i_d,
  output logic             o_msb
);

  logic [PAT_W-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_d;
    end else if (i_shift) begin
      r_sr <= {r_sr[PAT_W-2:0], i_si};
    end
  end

  assign o_msb = r_sr[PAT_W-1];

endmodule : seq_gen_shreg
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : seq_gen
//  Purpose  : Serial pattern generator. On start, transmits a 4-bit pattern
//             MSB first, repeated reps times with gap idle cycles between
//             repetitions. A is taken straight from a flop so it can drive a
//             downstream sequence detector directly.
//  Ports    : clk      - clock, rising edge
//             clr      - synchronous active-high reset
//             start    - begin a stream (ignored while busy or if reps == 0)
//             pattern  - word to send, MSB first
//             reps     - repetition count 1..15
//             gap      - idle cycles between repetitions 0..3
//             idle_bit - level on A when no pattern bit is being sent
//             A        - registered serial data
//             busy     - high in SHIFT or GAP
//             last     - high while the final bit of a repetition is on A
//             done     - one-cycle pulse after the final bit of the stream
//  Revision : 1.0  initial release
// ============================================================================
module seq_gen
  import seq_gen_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  input  logic             idle_bit,
  output logic             A,
  output logic             busy,
  output logic             last,
  output logic             done
);

  localparam logic [IDX_W-1:0] c_TOP_IDX = IDX_W'(PAT_W - 1);

  state_t           r_state,    w_state_nxt;
  logic [IDX_W-1:0] r_bit_idx,  w_bit_idx_nxt;
  logic [REP_W-1:0] r_rep_cnt,  w_rep_cnt_nxt;
  logic [GAP_W-1:0] r_gap_cnt,  w_gap_cnt_nxt;
  logic [GAP_W-1:0] r_gap_lat,  w_gap_lat_nxt;
  logic [PAT_W-1:0] r_pat,      w_pat_nxt;
  logic             r_done,     w_done_nxt;

  logic             w_load;
  logic             w_shift;
  logic [PAT_W-1:0] w_ld_data;
  logic             w_msb;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= IDLE;
      r_bit_idx <= '0;
      r_rep_cnt <= '0;
      r_gap_cnt <= '0;
      r_gap_lat <= '0;
      r_pat     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_gap_lat <= w_gap_lat_nxt;
      r_pat     <= w_pat_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // The shift register is the sole source of A. Whenever no pattern bit is
  // due next cycle it is reloaded with idle_bit in every position, which
  // gives A the one-cycle-latency tracking of the live idle_bit.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_rep_cnt_nxt = r_rep_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_gap_lat_nxt = r_gap_lat;
    w_pat_nxt     = r_pat;
    w_done_nxt    = 1'b0;
    w_load        = 1'b1;
    w_shift       = 1'b0;
    w_ld_data     = {PAT_W{idle_bit}};

    unique case (r_state)
      IDLE: begin
        if (start && (reps != '0)) begin
          w_pat_nxt     = pattern;
          w_rep_cnt_nxt = reps;
          w_gap_lat_nxt = gap;
          w_bit_idx_nxt = c_TOP_IDX;
          w_ld_data     = pattern;
          w_state_nxt   = SHIFT;
        end
      end

      SHIFT: begin
        if (r_bit_idx != '0) begin
          w_load        = 1'b0;
          w_shift       = 1'b1;
          w_bit_idx_nxt = r_bit_idx - IDX_W'(1);
        end else if (r_rep_cnt > REP_W'(1)) begin
          w_rep_cnt_nxt = r_rep_cnt - REP_W'(1);
          if (r_gap_lat == '0) begin
            w_bit_idx_nxt = c_TOP_IDX;
            w_ld_data     = r_pat;
          end else begin
            w_gap_cnt_nxt = r_gap_lat;
            w_state_nxt   = GAP;
          end
        end else begin
          w_rep_cnt_nxt = '0;
          w_done_nxt    = 1'b1;
          w_state_nxt   = IDLE;
        end
      end

      GAP: begin
        // r_gap_cnt counts gap..1; the pattern reload happens on the edge
        // that ends the last idle cycle.
        if (r_gap_cnt == GAP_W'(1)) begin
          w_gap_cnt_nxt = '0;
          w_bit_idx_nxt = c_TOP_IDX;
          w_ld_data     = r_pat;
          w_state_nxt   = SHIFT;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  seq_gen_shreg u_shreg (
    .clk     (clk),
    .clr     (clr),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_si    (idle_bit),
    .i_d     (w_ld_data),
    .o_msb   (w_msb)
  );

  assign A    = w_msb;
  assign busy = (r_state != IDLE);
  assign last = (r_state == SHIFT) && (r_bit_idx == '0);
  assign done = r_done;

endmodule : seq_gen
`default_nettype wire
